counter_mod_updown: RTL and testbench
=====================================

// Module: counter_mod_updown
// PURPOSE
//  Parametrised successor to the team's 4-bit load/inc counter.
//  - Modulo-N up/down counter with programmable step, parallel load and clock enable.
//  - Adds terminal-count flags and a one-cycle boundary pulse.
//  - Sits beside control FSMs as a tick/index generator; fully synchronous, registered outputs.
// PARAMETERS
//  WIDTH      4   counter/data width in bits
//  MODULUS    16  count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0   value of out after reset; must be < MODULUS
// PORTS
//  clk       in   1      single clock, all state updates on posedge
//  reset     in   1      synchronous, active-high reset
//  enable    in   1      1 = load/count allowed this cycle, 0 = hold everything
//  load      in   1      parallel load of in
//  in        in   WIDTH  load value
//  inc       in   1      count up by step (level-sampled each posedge)
//  dec       in   1      count down by step
//  step      in   WIDTH  increment magnitude
//  out       out  WIDTH  current count (register)
//  tc_up     out  1      out == MODULUS-1 (combinational from out)
//  tc_dn     out  1      out == 0 (combinational from out)
//  wrap      out  1      registered 1-cycle pulse: last update crossed a boundary
//  load_err  out  1      registered 1-cycle pulse: last load value was out of range
// BEHAVIOUR
//  - Clock/reset: one clock, clk. Reset is synchronous and active-high on port reset.
//  - Reset values: out=RESET_VAL, wrap=0, load_err=0.
//  - Priority per posedge: reset > !enable (hold) > load > inc/dec.
//  - Latency: 1 cycle. Inputs sampled at edge k; out/wrap/load_err valid after edge k.
//  - Pulses: wrap and load_err are 0 on every cycle that does not set them, including hold cycles.
//  - Load: in < MODULUS loads in. Otherwise out=MODULUS-1 and load_err=1 for one cycle.
//    load ignores inc/dec that cycle.
//  - inc&dec both 1, both 0, or eff_step==0: hold, wrap=0.
//  - eff_step = min(step, MODULUS-1). Arithmetic is done WIDTH+1 bits wide (no silent overflow).
//  - Up: s = out+eff_step.
//    s > MODULUS-1 -> out = s-MODULUS, wrap=1; else out=s.
//  - Down: out < eff_step -> out = out+MODULUS-eff_step, wrap=1; else out = out-eff_step.
//  - Reset mid-count overrides any load/inc/dec in the same cycle.
//  - tc_up/tc_dn are pure decodes of out; no extra latency.
// CONFIGURATION
//  - Macro: COUNTER_SAT_EN.
//  - Undefined (default): modulo wrap as above.
//  - Defined: saturating arithmetic.
//    Up overflow -> out=MODULUS-1; down underflow -> out=0.
//    wrap=1 for one cycle whenever a step was clipped.
//    Already at the limit and stepping further: out holds, wrap=1.
//  - Load/reset/enable behaviour is identical in both builds.
// STRUCTURE
//  - Package counter_pkg:
//    op encoding CNT_HOLD/CNT_LOAD/CNT_UP/CNT_DN (2-bit localparams);
//    function clamp_step(step, MODULUS).
//  - Sub-module counter_step_alu (combinational): takes op, out, eff_step, in;
//    returns next, wrap_n, load_err_n.
//    Owns both the modulo and the COUNTER_SAT_EN saturate path.
//  - Top: op decode, priority, registers, tc decodes.
// TESTING (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted)
//  1. reset=1 two cycles -> out=0, tc_dn=1, wrap=0.
//     Then inc=1, step=1 for 12 cycles -> out 1..9,0,1,2; tc_up=1 at 9; wrap=1 only on the 9->0 cycle.
//  2. load=1 in=5 -> out=5, load_err=0.
//     load=1 in=12 -> out=9, load_err=1 for one cycle; load+inc same cycle -> load wins.
//  3. out=2, dec=1 step=3 -> out=9, wrap=1.
//     With COUNTER_SAT_EN: out=0, wrap=1; a further dec -> out=0, wrap=1.
//  4. enable=0 with load=1 in=7 and inc=1 -> out unchanged, wrap=load_err=0.
//     enable=1, inc=dec=1 -> out unchanged.
//  5. reset=1 on the same edge as load=1 in=4 -> out=RESET_VAL.
//     Rerun with RESET_VAL=3 -> out=3 after reset.
//  6. step=0 inc=1 -> hold.
//     step=15 from out=0 inc=1 -> out=9 (step clamped to 9), wrap=0; next inc -> out=8, wrap=1.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: op encoding and step clamp shared by the counter and its ALU
package counter_pkg;
  localparam logic [1:0] CNT_HOLD = 2'd0;
  localparam logic [1:0] CNT_LOAD = 2'd1;
  localparam logic [1:0] CNT_UP   = 2'd2;
  localparam logic [1:0] CNT_DN   = 2'd3;
  function automatic int unsigned clamp_step(input int unsigned step, input int unsigned modulus);
    return (step > modulus - 1) ? modulus - 1 : step;
  endfunction
endpackage

// File: rtl/counter_step_alu.sv
// counter_step_alu: next-count datapath, modulo wrap by default, saturating when COUNTER_SAT_EN is defined
module counter_step_alu
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] eff_step,
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] next,
  output logic             wrap_n,
  output logic             load_err_n
);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX = MOD - 1'b1;
  logic [WIDTH:0] cur_x, stp_x, in_x, sum, res;
  logic           over, under;
  assign cur_x = {1'b0, cur};
  assign stp_x = {1'b0, eff_step};
  assign in_x  = {1'b0, in_val};
  assign sum   = cur_x + stp_x;
  assign over  = sum > MAX;
  assign under = cur_x < stp_x;
  // Select next value; arithmetic stays one bit wider than the count so nothing overflows silently
  always_comb begin
    res        = cur_x;
    wrap_n     = 1'b0;
    load_err_n = 1'b0;
    if (op == CNT_LOAD) begin
      load_err_n = in_x > MAX;
      res        = load_err_n ? MAX : in_x;
    end else if (op == CNT_UP) begin
      wrap_n = over;
`ifdef COUNTER_SAT_EN
      res    = over ? MAX : sum;
`else
      res    = over ? sum - MOD : sum;
`endif
    end else if (op == CNT_DN) begin
      wrap_n = under;
`ifdef COUNTER_SAT_EN
      res    = under ? '0 : cur_x - stp_x;
`else
      res    = under ? cur_x + MOD - stp_x : cur_x - stp_x;
`endif
    end
    next = res[WIDTH-1:0];
  end
endmodule

// File: rtl/counter_mod_updown.sv
// counter_mod_updown: modulo-N up/down counter with load, step and flags; COUNTER_SAT_EN selects saturation
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] out,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             wrap,
  output logic             load_err
);
  logic [WIDTH-1:0] out_q, out_d, eff_step;
  logic             wrap_q, wrap_d, err_q, err_d;
  logic [1:0]       op;
  assign eff_step = WIDTH'(clamp_step(32'(step), MODULUS));
  // Load beats counting; conflicting or zero-sized steps collapse to hold
  always_comb begin
    op = load ? CNT_LOAD : ((inc ^ dec) && eff_step != '0) ? (inc ? CNT_UP : CNT_DN) : CNT_HOLD;
  end
  counter_step_alu #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_alu (
    .op(op), .cur(out_q), .eff_step(eff_step), .in_val(in),
    .next(out_d), .wrap_n(wrap_d), .load_err_n(err_d)
  );
  // State register: reset, then hold (pulses cleared) when disabled, else take ALU result
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= WIDTH'(RESET_VAL);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (!enable) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign out      = out_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
  assign tc_up    = out_q == WIDTH'(MODULUS - 1);
  assign tc_dn    = out_q == '0;
endmodule

// File: tb/tb_counter_mod_updown.sv
// tb_counter_mod_updown: directed self-checking bench for counter_mod_updown (WIDTH=4, MODULUS=10)
module tb_counter_mod_updown;
  logic       clk = 0, reset, enable, load, inc, dec;
  logic [3:0] in, step, out, out3;
  logic       tc_up, tc_dn, wrap, load_err, tc_up3, tc_dn3, wrap3, err3;
  int         n_tests = 0, n_fail = 0;
  int         cur;
  always #5 clk = ~clk;
  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .in(in), .inc(inc), .dec(dec),
    .step(step), .out(out), .tc_up(tc_up), .tc_dn(tc_dn), .wrap(wrap), .load_err(load_err)
  );
  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .in(in), .inc(inc), .dec(dec),
    .step(step), .out(out3), .tc_up(tc_up3), .tc_dn(tc_dn3), .wrap(wrap3), .load_err(err3)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1; enable = 1; load = 0; in = 0; inc = 0; dec = 0; step = 0;
    #1;
    tick(); tick();
    chk("rst_out", out, 0); chk("rst_tc_dn", tc_dn, 1); chk("rst_wrap", wrap, 0);
    chk("rst_err", load_err, 0); chk("rst3_out", out3, 3);
    reset = 0; inc = 1; step = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("up_out_%0d", i), out, i % 10);
      chk($sformatf("up_wrap_%0d", i), wrap, int'(i == 10));
      chk($sformatf("up_tc_%0d", i), tc_up, int'(i == 9));
    end
    inc = 0; load = 1; in = 5;
    tick(); chk("ld5_out", out, 5); chk("ld5_err", load_err, 0);
    in = 12;
    tick(); chk("ld12_out", out, 9); chk("ld12_err", load_err, 1); chk("ld12_tc", tc_up, 1);
    load = 0;
    tick(); chk("err_pulse_out", out, 9); chk("err_pulse_clr", load_err, 0);
    load = 1; in = 3; inc = 1;
    tick(); chk("ldinc_out", out, 3); chk("ldinc_wrap", wrap, 0);
    inc = 0; in = 2;
    tick(); chk("ld2_out", out, 2);
    load = 0; dec = 1; step = 3;
    tick();
`ifdef COUNTER_SAT_EN
    chk("dn_sat_out", out, 0); chk("dn_sat_wrap", wrap, 1);
    tick(); chk("dn_sat2_out", out, 0); chk("dn_sat2_wrap", wrap, 1);
`else
    chk("dn_wrap_out", out, 9); chk("dn_wrap_wrap", wrap, 1);
    tick(); chk("dn2_out", out, 6); chk("dn2_wrap", wrap, 0);
`endif
    dec = 0; load = 1; in = 12;
    tick(); chk("ld_err_again", load_err, 1);
    cur = 9;
    enable = 0; in = 7; inc = 1;
    tick(); chk("hold_out", out, cur); chk("hold_wrap", wrap, 0); chk("hold_err", load_err, 0);
    enable = 1; load = 0; dec = 1; step = 1;
    tick(); chk("incdec_out", out, cur); chk("incdec_wrap", wrap, 0);
    dec = 0; inc = 0; reset = 1; load = 1; in = 4;
    tick(); chk("rstld_out", out, 0); chk("rstld3_out", out3, 3); chk("rstld_err", load_err, 0);
    reset = 0; load = 0; inc = 1; step = 0;
    tick(); chk("step0_out", out, 0); chk("step0_wrap", wrap, 0);
    step = 15;
    tick(); chk("clamp_out", out, 9); chk("clamp_wrap", wrap, 0); chk("clamp_tc", tc_up, 1);
    tick();
`ifdef COUNTER_SAT_EN
    chk("clamp2_out", out, 9);
`else
    chk("clamp2_out", out, 8);
`endif
    chk("clamp2_wrap", wrap, 1);
    inc = 0;
    tick(); chk("wrap_clr", wrap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
